fetch_byte_sequencer: RTL
=========================

FETCH_BYTE_SEQUENCER -- requirements
Module: fetch_byte_sequencer

Interface
REQ-001 Parameter MAX_LEN, default 15: maximum legal instruction length in bytes.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 flush  input  1  synchronous abort of the current instruction (branch redirect).
REQ-005 byte_valid  input  1  byte_in carries a fetched instruction byte.
REQ-006 byte_in  input  8  instruction byte.
REQ-007 byte_ready  output  1  sequencer accepts byte_in this cycle; accept means byte_valid&&byte_ready.
REQ-008 op_modrm  input  1  opcode decoder hint: the opcode being accepted takes a ModRM byte.
REQ-009 op_imm_size  input  4  opcode decoder hint: immediate bytes, legal values 0,1,2,4,8.
REQ-010 phase  output  3  current byte role: 0 PREFIX, 1 OPC1, 2 OPC2, 3 MODRM, 4 SIB, 5 DISP, 6 IMM, 7 END.
REQ-011 rex  output  4  captured REX.WRXB of the current instruction.
REQ-012 inst_len  output  4  bytes accepted for the current instruction.
REQ-013 inst_done  output  1  one-cycle pulse: instruction fully consumed.
REQ-014 inst_err  output  1  one-cycle pulse: instruction exceeded MAX_LEN.

Function
REQ-015 States: PREFIX, OPC1, OPC2, MODRM, SIB, DISP, IMM, DONE, ERR; phase = state index, DONE/ERR both report 7.
REQ-016 byte_ready = 1 in PREFIX..IMM, 0 in DONE, ERR, and while rst high; at most one byte accepted per cycle.
REQ-017 PREFIX: legacy prefixes 26,2E,36,3E,64,65,66,67,F0,F2,F3 stay in PREFIX and clear rex; any other byte is treated as the first opcode byte with OPC1 rules applied same cycle.
REQ-018 First opcode byte 0F -> OPC2; otherwise hints sampled that cycle: op_modrm -> MODRM, else op_imm_size!=0 -> IMM, else DONE.
REQ-019 OPC2: byte accepted, hints sampled that cycle, same successor rules as REQ-018.
REQ-020 MODRM: mod=11 -> no disp; mod=01 -> disp 1; mod=10 -> disp 4; mod=00 & rm=101 -> disp 4; rm=100 & mod!=11 -> SIB first.
REQ-021 SIB: base=101 & mod=00 -> disp 4; then DISP if disp>0, else IMM if imm>0, else DONE.
REQ-022 DISP/IMM: down-counter loaded with size, decremented per accepted byte; last byte -> next phase (IMM or DONE); imm size latched at opcode acceptance.
REQ-023 inst_len increments per accepted byte; the byte that would make it MAX_LEN+1 -> ERR instead of its normal transition.
REQ-024 DONE: inst_done=1 for exactly one cycle, inst_len/rex hold final values; next cycle -> PREFIX, inst_len=0, rex=0.
REQ-025 ERR: inst_err=1 for one cycle; next cycle -> PREFIX with inst_len=0, rex=0.
REQ-026 flush has priority over byte acceptance: next state PREFIX, counters and rex cleared, no done/err pulse.
REQ-027 byte_valid low holds all state; counters never wrap.

Reset
REQ-028 rst high -> state PREFIX, rex=0, inst_len=0, counters 0, inst_done=0, inst_err=0, immediately and asynchronously.
REQ-029 rst mid-instruction discards partial instruction; no pulse on release.

Configuration
REQ-030 Macro FETCH_SEQ_REX_EN defined: in PREFIX, bytes 40-4F are accepted as REX, load rex=byte[3:0], stay in PREFIX.
REQ-031 Macro undefined: 40-4F are opcode bytes under REQ-018, rex output tied to 0.

Verification
REQ-032 Bytes 90 with op_modrm=0, imm=0 -> phases 0->DONE, inst_done after 1 byte, inst_len=1.
REQ-033 48 89 84 24 10 00 00 00 (REX_EN, op_modrm=1) -> SIB then 4 disp bytes, rex=8, inst_len=8.
REQ-034 0F 84 xx xx xx xx (op_imm_size=4 on 84) -> OPC2 then IMM, inst_len=6.
REQ-035 Sixteen 66 bytes -> inst_err on 16th accept, no inst_done, returns to PREFIX.
REQ-036 flush asserted during DISP of 8B 80 with byte_valid=1 -> PREFIX next cycle, inst_len=0, no pulse.
REQ-037 rst asserted mid-IMM -> outputs at reset values same cycle; 90 after release completes normally, inst_len=1.

Source files
------------

// File: rtl/fetch_byte_sequencer.sv
// fetch_byte_sequencer: walks x86 instruction bytes through prefix/opcode/ModRM/SIB/disp/imm phases.
// Optional REX capture in PREFIX when FETCH_SEQ_REX_EN is defined.
module fetch_byte_sequencer #(
  parameter int MAX_LEN = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  output logic       byte_ready,
  input  logic       op_modrm,
  input  logic [3:0] op_imm_size,
  output logic [2:0] phase,
  output logic [3:0] rex,
  output logic [3:0] inst_len,
  output logic       inst_done,
  output logic       inst_err
);
  typedef enum logic [3:0] {
    S_PREFIX, S_OPC1, S_OPC2, S_MODRM, S_SIB, S_DISP, S_IMM, S_DONE, S_ERR
  } state_t;
  state_t state, state_n;
  logic [3:0] rex_r, rex_n, len_n, cnt, cnt_n, imm, imm_n, d;
  logic [1:0] mod_r, mod_n;
  logic accept, is_prefix, is_rex, op_go, tail_go;
  assign byte_ready = !rst && (state < S_DONE);
  assign accept = byte_valid && byte_ready;
  assign is_prefix = byte_in inside {8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65,
                                     8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3};
`ifdef FETCH_SEQ_REX_EN
  assign is_rex = byte_in[7:4] == 4'h4;
  assign rex = rex_r;
`else
  assign is_rex = 1'b0;
  assign rex = '0;
`endif
  assign phase = (state >= S_DONE) ? 3'd7 : state[2:0];
  assign inst_done = state == S_DONE;
  assign inst_err = state == S_ERR;
  always_comb begin
    state_n = state;
    rex_n = rex_r;
    len_n = inst_len;
    cnt_n = cnt;
    imm_n = imm;
    mod_n = mod_r;
    d = '0;
    op_go = 1'b0;
    tail_go = 1'b0;
    if (flush || state >= S_DONE) begin
      state_n = S_PREFIX;
      rex_n = '0;
      len_n = '0;
      cnt_n = '0;
      imm_n = '0;
      mod_n = '0;
    end else if (accept && inst_len == 4'(MAX_LEN)) begin
      state_n = S_ERR;
    end else if (accept) begin
      len_n = inst_len + 4'd1;
      case (state)
        S_PREFIX, S_OPC1: begin
          if (state == S_PREFIX && is_prefix) rex_n = '0;
          else if (state == S_PREFIX && is_rex) rex_n = byte_in[3:0];
          else if (byte_in == 8'h0F) state_n = S_OPC2;
          else op_go = 1'b1;
        end
        S_OPC2: op_go = 1'b1;
        S_MODRM: begin
          mod_n = byte_in[7:6];
          d = (byte_in[7:6] == 2'b01) ? 4'd1 :
              (byte_in[7:6] == 2'b10 || (byte_in[7:6] == 2'b00 && byte_in[2:0] == 3'b101)) ? 4'd4 : 4'd0;
          if (byte_in[2:0] == 3'b100 && byte_in[7:6] != 2'b11) begin
            state_n = S_SIB;
            cnt_n = d;
          end else tail_go = 1'b1;
        end
        S_SIB: begin
          d = (mod_r == 2'b00 && byte_in[2:0] == 3'b101) ? 4'd4 : cnt;
          tail_go = 1'b1;
        end
        S_DISP: begin
          if (cnt <= 4'd1) tail_go = 1'b1;
          else cnt_n = cnt - 4'd1;
        end
        S_IMM: begin
          state_n = (cnt <= 4'd1) ? S_DONE : S_IMM;
          cnt_n = (cnt <= 4'd1) ? 4'd0 : cnt - 4'd1;
        end
        default: state_n = S_PREFIX;
      endcase
      // Opcode hints are only meaningful on the cycle the opcode byte is accepted.
      if (op_go) begin
        imm_n = op_imm_size;
        state_n = op_modrm ? S_MODRM : (op_imm_size != 4'd0) ? S_IMM : S_DONE;
        cnt_n = op_modrm ? 4'd0 : op_imm_size;
      end
      if (tail_go) begin
        state_n = (d != 4'd0) ? S_DISP : (imm != 4'd0) ? S_IMM : S_DONE;
        cnt_n = (d != 4'd0) ? d : imm;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_PREFIX;
      rex_r <= '0;
      inst_len <= '0;
      cnt <= '0;
      imm <= '0;
      mod_r <= '0;
    end else begin
      state <= state_n;
      rex_r <= rex_n;
      inst_len <= len_n;
      cnt <= cnt_n;
      imm <= imm_n;
      mod_r <= mod_n;
    end
  end
endmodule
